mii_rx_deframer: RTL and testbench
==================================

// Module: mii_rx_deframer
// PURPOSE
//  64-bit/8-lane MII receive deframer; sits directly downstream of MII_gen (o_mii_tx_d/o_control/o_txValid).
//  Finds START (8'hFB) in lane 0 and checks the preamble/SFD. Strips control characters and emits DA..FCS as a
//  byte-enabled 64-bit stream with sof/eof/err. Flags framing and length errors; keeps saturating good/bad frame counters.
// PARAMETERS
//  PAYLOAD_MAX_SIZE  1500  max client payload bytes; max frame = PAYLOAD_MAX_SIZE+18 (DA..FCS)
//  MIN_FRAME_BYTES   64    min frame bytes DA..FCS (46 payload + 18)
//  CNT_W             32    statistics counter width
// PORTS
//  clk           in   1      clock
//  i_rst_n       in   1      reset: asynchronous, active-low
//  i_valid       in   1      input word qualifier; 0 => word treated as 8x IDLE (8'h07, ctrl 8'hFF)
//  i_mii_d       in   64     lane k = bits[8k+7:8k], lane 0 first on wire
//  i_mii_ctrl    in   8      bit k=1 => lane k is a control character
//  o_data        out  64     frame bytes, lane 0 first
//  o_keep        out  8      valid-byte mask, contiguous from lane 0 (8'hFF except on eof word)
//  o_valid       out  1      o_data/o_keep qualifier
//  o_sof         out  1      first word of frame (DA in lane 0); only with o_valid
//  o_eof         out  1      last word of frame; only with o_valid
//  o_err         out  1      with o_eof: frame bad (framing/length); frame-level, not per word
//  o_good_cnt    out  CNT_W  frames ended with o_eof & !o_err, saturating
//  o_bad_cnt     out  CNT_W  frames ended with o_eof & o_err, saturating
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; hold register empty; byte count 0.
//  States: IDLE, FRAME, DROP.
//  IDLE: word with ctrl[0]=1 & d[7:0]=FB -> check lanes1..7 = 55,55,55,55,55,55,D5 with ctrl[7:1]=0.
//   Check pass -> FRAME, byte_cnt=0; fail -> DROP, bad_cnt+1 (nothing emitted). FB in lanes 1..7 ignored.
//  FRAME: lanes before first ctrl lane are data. First ctrl lane FD at lane t -> frame ends, t bytes in this word
//   (t=0 legal: previous word is last). Any other ctrl char in frame (e.g. FE, 07, FB) -> end, err=1 -> IDLE.
//   i_valid=0 in FRAME counts as 07 in lane 0 -> abort, err=1.
//  Length: byte_cnt += data bytes, saturating at 16'hFFFF. At end err |= (cnt<MIN_FRAME_BYTES)|(cnt>PAYLOAD_MAX_SIZE+18).
//   cnt>max seen mid-frame -> keep emitting; err set at eof.
//  DROP: discard until lane with ctrl=1 & FD, or an all-idle word -> IDLE.
//  One-word hold register: data word N is presented on the cycle after word N+1 is sampled, so eof/keep are known.
//   Latency: input sample edge -> o_valid high = 2 clk. o_valid is never high in back-to-back gaps > 1 word.
//  End word with t=0: hold word emitted with o_eof=1, o_keep=FF. End word with t>0: hold word emitted normally;
//   next cycle emits the end word with o_keep=(1<<t)-1, o_eof=1.
//  Counters update in the same cycle as o_eof. Saturate at all-ones, never wrap.
//  START in the same word as FD (back-to-back frames): not supported; the START is ignored and FSM -> IDLE.
//  MII_gen ends every packet this way (min IFG 12 idle bytes).
//  Reset mid-frame: all state cleared immediately; partial frame neither emitted nor counted.
//  No backpressure: downstream must accept every o_valid word.
// STRUCTURE
//  mii_pkg: IDLE_CODE=8'h07, START_CODE=8'hFB, EOF_CODE=8'hFD, ERR_CODE=8'hFE, PREAMBLE=8'h55, SFD=8'hD5,
//   and typedef enum rx_state_t {IDLE,FRAME,DROP}. Shared with MII_gen.
//  Sub-module mii_rx_stats: two saturating CNT_W counters, inputs good_pulse/bad_pulse.
//  Top level holds the FSM, first-ctrl-lane priority encoder, byte counter and hold register.
// TESTING
//  1 Chain MII_gen(PAYLOAD_LENGTH=46) -> DUT: one 64-byte frame. Expect sof, 8 words, last o_keep=FF, eof, err=0.
//    Expect good_cnt=1; bytes equal generator DA..FCS.
//  2 MII_gen PAYLOAD_LENGTH=50 (68B, FD at lane 4 of word 9): expect last o_keep=8'h0F, eof, err=0.
//  3 Inject FE (ctrl=1) at lane 3 of word 5: expect eof on that word, o_keep=8'h07, err=1, bad_cnt=1.
//    Next frame is received good.
//  4 Start word lane 7 = 8'h55 (bad SFD): expect no o_valid for that frame, bad_cnt+1, FSM back to IDLE at FD.
//  5 Frames of 60B and 1519B: both eof with err=1. 1518B frame: err=0.
//  6 Assert i_rst_n low mid-frame: outputs 0 asynchronously, counters 0. Next frame received good.
//    Force bad_cnt to all-ones, then one bad frame: counter stays all-ones.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared MII definitions: control codes, receive FSM states and a lane-mask helper.
package mii_pkg;

  localparam logic [7:0] IDLE_CODE  = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] EOF_CODE   = 8'hFD;
  localparam logic [7:0] ERR_CODE   = 8'hFE;
  localparam logic [7:0] PREAMBLE   = 8'h55;
  localparam logic [7:0] SFD        = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DROP
  } rx_state_t;

  // Byte-enable mask with the lowest 'lanes' lanes set (lanes = 0..7).
  function automatic logic [7:0] keep_mask(input logic [2:0] lanes);
    keep_mask = 8'((9'd1 << lanes) - 9'd1);
  endfunction

endpackage

// File: rtl/mii_rx_stats.sv
// Saturating good/bad frame counters for the MII receive deframer.
module mii_rx_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             good_pulse,
  input  logic             bad_pulse,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  // Count each pulse, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (good_pulse && (good_cnt != '1)) good_cnt <= good_cnt + CNT_W'(1);
      if (bad_pulse && (bad_cnt != '1))   bad_cnt  <= bad_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// 64-bit / 8-lane MII receive deframer: finds START + preamble/SFD, strips control
// characters and emits DA..FCS as a byte-enabled stream with sof/eof/err and statistics.
module mii_rx_deframer #(
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int MIN_FRAME_BYTES  = 64,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [63:0]      i_mii_d,
  input  logic [7:0]       i_mii_ctrl,
  output logic [63:0]      o_data,
  output logic [7:0]       o_keep,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_err,
  output logic [CNT_W-1:0] o_good_cnt,
  output logic [CNT_W-1:0] o_bad_cnt
);

  import mii_pkg::*;

  localparam logic [15:0] MIN_BYTES = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_BYTES = 16'(PAYLOAD_MAX_SIZE + 18);

  rx_state_t   state, state_n;

  logic [63:0] in_d;
  logic [7:0]  in_ctrl;

  logic        has_ctrl;
  logic [2:0]  ctrl_lane;
  logic [7:0]  ctrl_byte;
  logic        start_hit, preamble_ok, fd_any, all_idle;

  logic [15:0] byte_cnt, cnt_n, cnt_sat;
  logic [16:0] cnt_sum;
  logic [3:0]  add_bytes;
  logic        len_err, end_err;

  logic [63:0] hold_data;
  logic [7:0]  hold_keep;
  logic        hold_valid, hold_sof, hold_last, hold_err;
  logic        sof_pend, sof_pend_n;

  logic        emit, emit_sof, emit_eof, emit_err;
  logic [7:0]  emit_keep;
  logic        load_hold, load_last, load_err, clear_hold;
  logic [7:0]  load_keep;
  logic        good_p, bad_p;

  // Input stage; an unqualified word is replaced by eight IDLE control characters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_d    <= '0;
      in_ctrl <= '0;
    end else if (i_valid) begin
      in_d    <= i_mii_d;
      in_ctrl <= i_mii_ctrl;
    end else begin
      in_d    <= {8{IDLE_CODE}};
      in_ctrl <= 8'hFF;
    end
  end

  // Lowest control lane in the word and word-level control-character detectors.
  always_comb begin
    has_ctrl  = 1'b0;
    ctrl_lane = 3'd0;
    fd_any    = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (in_ctrl[k]) begin
        has_ctrl  = 1'b1;
        ctrl_lane = 3'(k);
      end
      if (in_ctrl[k] && (in_d[8*k +: 8] == EOF_CODE)) fd_any = 1'b1;
    end
    ctrl_byte   = in_d[{ctrl_lane, 3'b000} +: 8];
    start_hit   = in_ctrl[0] && (in_d[7:0] == START_CODE);
    preamble_ok = (in_ctrl[7:1] == 7'd0) && (in_d[63:8] == {SFD, {6{PREAMBLE}}});
    all_idle    = (in_ctrl == 8'hFF) && (in_d == {8{IDLE_CODE}});
  end

  // Saturating frame length including this word's data bytes.
  always_comb begin
    add_bytes = has_ctrl ? {1'b0, ctrl_lane} : 4'd8;
    cnt_sum   = {1'b0, byte_cnt} + 17'(add_bytes);
    cnt_sat   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    len_err   = (cnt_sat < MIN_BYTES) || (cnt_sat > MAX_BYTES);
    end_err   = (ctrl_byte != EOF_CODE) || len_err;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state, hold-register control and output selection.
  always_comb begin
    state_n    = state;
    emit       = 1'b0;
    emit_keep  = 8'hFF;
    emit_sof   = hold_sof;
    emit_eof   = 1'b0;
    emit_err   = 1'b0;
    load_hold  = 1'b0;
    load_keep  = 8'hFF;
    load_last  = 1'b0;
    load_err   = 1'b0;
    clear_hold = 1'b0;
    cnt_n      = byte_cnt;
    sof_pend_n = sof_pend;
    good_p     = 1'b0;
    bad_p      = 1'b0;

    if (hold_valid && hold_last) begin
      emit       = 1'b1;
      emit_keep  = hold_keep;
      emit_eof   = 1'b1;
      emit_err   = hold_err;
      clear_hold = 1'b1;
      good_p     = !hold_err;
      bad_p      = hold_err;
    end

    case (state)
      IDLE: begin
        if (start_hit) begin
          if (preamble_ok) begin
            state_n    = FRAME;
            cnt_n      = 16'd0;
            sof_pend_n = 1'b1;
          end else begin
            state_n = DROP;
            bad_p   = 1'b1;
          end
        end
      end
      FRAME: begin
        cnt_n = cnt_sat;
        if (!has_ctrl) begin
          emit       = hold_valid;
          load_hold  = 1'b1;
          sof_pend_n = 1'b0;
        end else begin
          state_n = IDLE;
          if (ctrl_lane == 3'd0) begin
            if (hold_valid) begin
              emit       = 1'b1;
              emit_eof   = 1'b1;
              emit_err   = end_err;
              clear_hold = 1'b1;
              good_p     = !end_err;
              bad_p      = end_err;
            end else begin
              bad_p = 1'b1;
            end
          end else begin
            emit       = hold_valid;
            load_hold  = 1'b1;
            load_keep  = keep_mask(ctrl_lane);
            load_last  = 1'b1;
            load_err   = end_err;
            sof_pend_n = 1'b0;
          end
        end
      end
      DROP: begin
        if (fd_any || all_idle) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Hold register, byte counter and registered output word.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_valid <= 1'b0;
      hold_sof   <= 1'b0;
      hold_last  <= 1'b0;
      hold_err   <= 1'b0;
      sof_pend   <= 1'b0;
      byte_cnt   <= '0;
      o_data     <= '0;
      o_keep     <= '0;
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      if (load_hold) begin
        hold_data  <= in_d;
        hold_keep  <= load_keep;
        hold_valid <= 1'b1;
        hold_sof   <= sof_pend;
        hold_last  <= load_last;
        hold_err   <= load_err;
      end else if (clear_hold) begin
        hold_valid <= 1'b0;
        hold_last  <= 1'b0;
      end
      sof_pend <= sof_pend_n;
      byte_cnt <= cnt_n;
      o_valid  <= emit;
      o_data   <= emit ? hold_data : '0;
      o_keep   <= emit ? emit_keep : '0;
      o_sof    <= emit && emit_sof;
      o_eof    <= emit && emit_eof;
      o_err    <= emit && emit_eof && emit_err;
    end
  end

  mii_rx_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .good_pulse (good_p),
    .bad_pulse  (bad_p),
    .good_cnt   (o_good_cnt),
    .bad_cnt    (o_bad_cnt)
  );

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed self-checking bench for mii_rx_deframer: frames built in MII_gen format,
// output words collected by a monitor and compared against the generated byte stream.
module tb_mii_rx_deframer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             i_rst_n;
  logic             i_valid;
  logic [63:0]      i_mii_d;
  logic [7:0]       i_mii_ctrl;
  logic [63:0]      o_data;
  logic [7:0]       o_keep;
  logic             o_valid, o_sof, o_eof, o_err;
  logic [CNT_W-1:0] o_good_cnt, o_bad_cnt;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        sof;
    logic        eof;
    logic        err;
    int          cyc;
  } outWord_t;

  outWord_t outQ[$];
  int       cyc = 0;
  int       vectors = 0;
  int       miscompares = 0;
  int       seed = 0;
  int       expGood = 0;
  int       expBad = 0;
  int       daCycle;

  mii_rx_deframer #(.PAYLOAD_MAX_SIZE(1500), .MIN_FRAME_BYTES(64), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_mii_d    (i_mii_d),
    .i_mii_ctrl (i_mii_ctrl),
    .o_data     (o_data),
    .o_keep     (o_keep),
    .o_valid    (o_valid),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_err      (o_err),
    .o_good_cnt (o_good_cnt),
    .o_bad_cnt  (o_bad_cnt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every qualified output word on the falling edge.
  always @(negedge clk) begin
    if (o_valid === 1'b1) outQ.push_back('{o_data, o_keep, o_sof, o_eof, o_err, cyc});
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] ctrl, input logic v);
    i_mii_d    = d;
    i_mii_ctrl = ctrl;
    i_valid    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idleWords(input int n);
    repeat (n) applyStimulus({8{8'h07}}, 8'hFF, 1'b1);
  endtask

  function automatic logic [7:0] frameByte(input int idx);
    return 8'((idx * 13 + seed) % 256);
  endfunction

  // Start word, data words, terminating FD word; optionally cut by FE or an i_valid=0 gap.
  task automatic sendFrame(input int n, input bit badSfd, input int cutWord, input int cutLane,
                           input bit cutGap, output int daCyc);
    logic [63:0] d;
    logic [7:0]  c;
    int          idx;
    daCyc = 0;
    applyStimulus({(badSfd ? 8'h55 : 8'hD5), {6{8'h55}}, 8'hFB}, 8'h01, 1'b1);
    for (int w = 1; w <= n / 8 + 1; w++) begin
      d = '0;
      c = '0;
      for (int l = 0; l < 8; l++) begin
        idx = (w - 1) * 8 + l;
        if (idx < n) d[8*l +: 8] = frameByte(idx);
        else begin
          d[8*l +: 8] = (idx == n) ? 8'hFD : 8'h07;
          c[l] = 1'b1;
        end
      end
      if (w == cutWord) begin
        if (cutGap) applyStimulus('0, '0, 1'b0);
        else begin
          d[8*cutLane +: 8] = 8'hFE;
          c[cutLane] = 1'b1;
          applyStimulus(d, c, 1'b1);
        end
        return;
      end
      applyStimulus(d, c, 1'b1);
      if (w == 1) daCyc = cyc;
    end
  endtask

  // Compare the captured words against the first nExp bytes of the current frame.
  task automatic checkFrame(input string tag, input int nExp, input bit errExp);
    int          nw;
    int          rem;
    logic [7:0]  expKeep;
    logic [63:0] expD, mask;
    nw = (nExp + 7) / 8;
    checkOutput($sformatf("%s words", tag), 64'(outQ.size()), 64'(nw));
    for (int i = 0; i < nw && i < outQ.size(); i++) begin
      rem = nExp - i * 8;
      expKeep = '0;
      expD = '0;
      mask = '0;
      for (int l = 0; l < 8; l++) begin
        if (l < rem) begin
          expKeep[l] = 1'b1;
          expD[8*l +: 8] = frameByte(i * 8 + l);
          mask[8*l +: 8] = 8'hFF;
        end
      end
      checkOutput($sformatf("%s w%0d data", tag, i), outQ[i].d & mask, expD);
      checkOutput($sformatf("%s w%0d keep", tag, i), 64'(outQ[i].k), 64'(expKeep));
      checkOutput($sformatf("%s w%0d sof", tag, i), 64'(outQ[i].sof), 64'(i == 0));
      checkOutput($sformatf("%s w%0d eof", tag, i), 64'(outQ[i].eof), 64'(i == nw - 1));
      checkOutput($sformatf("%s w%0d err", tag, i), 64'(outQ[i].err), 64'((i == nw - 1) && errExp));
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput($sformatf("%s good_cnt", tag), 64'(o_good_cnt), 64'(expGood));
    checkOutput($sformatf("%s bad_cnt", tag), 64'(o_bad_cnt), 64'(expBad));
  endtask

  task automatic runFrame(input string tag, input int n, input bit badSfd, input int cutWord,
                          input int cutLane, input bit cutGap, input int nExp, input bit errExp);
    seed = seed + 17;
    outQ.delete();
    sendFrame(n, badSfd, cutWord, cutLane, cutGap, daCycle);
    idleWords(4);
    checkFrame(tag, nExp, errExp);
    if (nExp > 0) begin
      if (errExp) expBad++;
      else        expGood++;
    end else begin
      expBad = (expBad < 15) ? expBad + 1 : 15;
    end
    checkCounters(tag);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_mii_d    = '0;
    i_mii_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset o_valid", 64'(o_valid), 64'd0);
    checkOutput("reset o_data", o_data, 64'd0);
    checkOutput("reset o_keep", 64'(o_keep), 64'd0);
    checkOutput("reset flags", 64'({o_sof, o_eof, o_err}), 64'd0);
    checkCounters("reset");
    i_rst_n = 1'b1;
    idleWords(2);

    runFrame("t1 64B", 64, 1'b0, 0, 0, 1'b0, 64, 1'b0);
    checkOutput("t1 latency", 64'((outQ.size() > 0) ? outQ[0].cyc - daCycle : -1), 64'd2);

    runFrame("t2 68B", 68, 1'b0, 0, 0, 1'b0, 68, 1'b0);

    runFrame("t3 FE", 64, 1'b0, 5, 3, 1'b0, 35, 1'b1);
    runFrame("t3 next", 64, 1'b0, 0, 0, 1'b0, 64, 1'b0);

    runFrame("t4 badSFD", 64, 1'b1, 0, 0, 1'b0, 0, 1'b0);
    runFrame("t4 next", 64, 1'b0, 0, 0, 1'b0, 64, 1'b0);

    runFrame("t5 60B", 60, 1'b0, 0, 0, 1'b0, 60, 1'b1);
    runFrame("t5 1519B", 1519, 1'b0, 0, 0, 1'b0, 1519, 1'b1);
    runFrame("t5 1518B", 1518, 1'b0, 0, 0, 1'b0, 1518, 1'b0);
    runFrame("gap abort", 64, 1'b0, 3, 0, 1'b1, 16, 1'b1);

    // Reset in the middle of a frame while an output word is on the bus.
    seed = seed + 17;
    outQ.delete();
    applyStimulus({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01, 1'b1);
    for (int w = 0; w < 3; w++) applyStimulus({8{8'hA5}} ^ 64'(w), 8'h00, 1'b1);
    #2;
    checkOutput("t6 pre-reset o_valid", 64'(o_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("t6 async o_valid", 64'(o_valid), 64'd0);
    checkOutput("t6 async o_data", o_data, 64'd0);
    checkOutput("t6 async flags", 64'({o_sof, o_eof, o_err}), 64'd0);
    expGood = 0;
    expBad  = 0;
    checkCounters("t6 async");
    outQ.delete();
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    idleWords(4);
    checkOutput("t6 partial dropped", 64'(outQ.size()), 64'd0);
    checkCounters("t6 after reset");
    runFrame("t6 next", 64, 1'b0, 0, 0, 1'b0, 64, 1'b0);

    // Drive the bad counter to all-ones, then once more to confirm it holds.
    for (int i = 0; i < 15; i++) begin
      seed = seed + 17;
      sendFrame(8, 1'b1, 0, 0, 1'b0, daCycle);
      idleWords(2);
    end
    expBad = 15;
    checkCounters("t6 bad full");
    runFrame("t6 saturate", 8, 1'b1, 0, 0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
